// File: rtl/turf_pkg.sv
// Shared constants for the PS/2 front end and game mechanics: key codes,
// direction encodings, set-2 scancodes and the receive-frame state type.
package turf_pkg;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned TMO_W = 16;

  localparam logic [KEY_W-1:0] KEY_IDLE  = 5'd31;
  localparam logic [KEY_W-1:0] KEY_RESET = 5'd16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Command code for a player/direction pair: 4*player + dir.
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] player,
                                                input logic [1:0] dir);
    return {1'b0, player, dir};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: input synchronisers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop checking and an inactivity timeout.
module ps2_rx_frame
  import turf_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_dat_s1, r_dat_s2;
  rx_state_t        r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_parity, w_parity_nxt;
  logic             r_byte_valid, w_byte_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_fall;
  logic             w_timeout;

  assign w_fall       = r_clk_prev & ~r_clk_s2;
  assign w_timeout    = (r_tmo_cnt == TMO_MAX) && !w_fall;
  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_err        = r_err;

  // Idle-high reset values keep a reset from looking like a clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_dat;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Saturating inactivity counter, restarted by every PS/2 falling edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tmo_cnt <= '0;
    end else if (w_fall) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_MAX) begin
      r_tmo_cnt <= TMO_W'(r_tmo_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_parity_nxt     = r_parity;
    w_byte_valid_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          if (!r_dat_s2) begin
            w_state_nxt   = RX_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_fall) begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = 3'(r_bit_cnt + 1'b1);
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (w_fall) begin
          w_parity_nxt = r_dat_s2;
          w_state_nxt  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_fall) begin
          w_state_nxt = RX_IDLE;
          if (r_dat_s2 && ((^r_shift) ^ r_parity)) begin
            w_byte_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
    if ((r_state != RX_IDLE) && w_timeout) begin
      w_state_nxt = RX_IDLE;
      w_err_nxt   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to game command encoder: tracks E0/F0 prefixes and maps make
// codes to 4*player+dir or the game-reset code; last-pressed key wins.
module ps2_key_encoder
  import turf_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_dat,
  output logic [KEY_W-1:0] KEY_PRESSED,
  output logic             key_valid,
  output logic             frame_err
);

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic             w_err;
  logic             r_ext;
  logic             r_brk;
  logic             w_hit;
  logic [KEY_W-1:0] w_code;

  ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk          (CLOCK_50),
    .resetn       (resetn),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_dat    (ps2_dat),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_err        (w_err)
  );

  // Scancode lookup; the E0 flag separates arrow keys from the keypad.
  always_comb begin
    w_hit  = 1'b1;
    w_code = KEY_IDLE;
    case ({r_ext, w_byte})
      {1'b0, SC_W}:     w_code = key_code(2'd0, DIR_UP);
      {1'b0, SC_S}:     w_code = key_code(2'd0, DIR_DOWN);
      {1'b0, SC_A}:     w_code = key_code(2'd0, DIR_LEFT);
      {1'b0, SC_D}:     w_code = key_code(2'd0, DIR_RIGHT);
      {1'b1, SC_UP}:    w_code = key_code(2'd1, DIR_UP);
      {1'b1, SC_DOWN}:  w_code = key_code(2'd1, DIR_DOWN);
      {1'b1, SC_LEFT}:  w_code = key_code(2'd1, DIR_LEFT);
      {1'b1, SC_RIGHT}: w_code = key_code(2'd1, DIR_RIGHT);
      {1'b0, SC_I}:     w_code = key_code(2'd2, DIR_UP);
      {1'b0, SC_K}:     w_code = key_code(2'd2, DIR_DOWN);
      {1'b0, SC_J}:     w_code = key_code(2'd2, DIR_LEFT);
      {1'b0, SC_L}:     w_code = key_code(2'd2, DIR_RIGHT);
      {1'b0, SC_KP8}:   w_code = key_code(2'd3, DIR_UP);
      {1'b0, SC_KP5}:   w_code = key_code(2'd3, DIR_DOWN);
      {1'b0, SC_KP4}:   w_code = key_code(2'd3, DIR_LEFT);
      {1'b0, SC_KP6}:   w_code = key_code(2'd3, DIR_RIGHT);
      {1'b0, SC_SPACE}: w_code = KEY_RESET;
      default:          w_hit  = 1'b0;
    endcase
  end

  // Prefix flags and output registers; a break only clears the displayed key.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      KEY_PRESSED <= KEY_IDLE;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= w_err;
      if (w_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_hit) begin
            if (r_brk) begin
              if (w_code == KEY_PRESSED) begin
                KEY_PRESSED <= KEY_IDLE;
              end
            end else begin
              KEY_PRESSED <= w_code;
              key_valid   <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: every visible output event is
// queued as expected when its frame is driven and checked when it appears.
module tb_ps2_key_encoder;

  localparam int HALF = 20;

  typedef struct packed {
    logic       kv;
    logic       fe;
    logic [4:0] key;
  } ev_t;

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [4:0] KEY_PRESSED;
  logic       key_valid;
  logic       frame_err;

  ev_t  exp_q[$];
  ev_t  m_e;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   stop_cyc;
  bit   lat_pending;
  bit   mon_en;
  logic [4:0] last_key;

  ps2_key_encoder dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .KEY_PRESSED (KEY_PRESSED),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit kv, input bit fe, input int key);
    ev_t e;
    e.kv  = kv;
    e.fe  = fe;
    e.key = 5'(key);
    exp_q.push_back(e);
  endtask

  // One PS/2 bit: data set while the clock is high, sampled on the fall.
  task automatic ps2_bit(input logic b, input bit is_stop);
    @(negedge clk);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == 10);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  // Output monitor: any pulse or code change must match the queue head.
  always @(negedge clk) begin
    if (mon_en && (key_valid || frame_err || KEY_PRESSED != last_key)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'({key_valid, frame_err, KEY_PRESSED}),
              int'({1'b0, 1'b0, last_key}));
      end else begin
        m_e = exp_q.pop_front();
        check("key_valid", int'(key_valid), int'(m_e.kv));
        check("frame_err", int'(frame_err), int'(m_e.fe));
        check("KEY_PRESSED", int'(KEY_PRESSED), int'(m_e.key));
      end
      if (lat_pending && key_valid) begin
        lat_pending = 1'b0;
        check("stop_to_valid_latency_3to6", int'((cyc - stop_cyc) >= 3 && (cyc - stop_cyc) <= 6), 1);
      end
      last_key = KEY_PRESSED;
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; stop_cyc = 0;
    lat_pending = 1'b0; mon_en = 1'b0; last_key = 5'd31;
    resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_key", int'(KEY_PRESSED), 31);
    check("reset_valid", int'(key_valid), 0);
    check("reset_err", int'(frame_err), 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Make W, then its break.
    lat_pending = 1'b1;
    push_exp(1, 0, 0);  send(8'h1D);
    push_exp(0, 0, 31); send(8'hF0); send(8'h1D);

    // Bad parity is dropped, then a good D.
    push_exp(0, 1, 31); send_frame(8'h1D, 1'b1, 11);
    push_exp(1, 0, 3);  send(8'h23);

    // Extended vs keypad 75; break of a non-displayed key is ignored.
    push_exp(1, 0, 4);  send(8'hE0); send(8'h75);
    push_exp(1, 0, 12); send(8'h75);
    send(8'hF0); send(8'hE0); send(8'h75);

    // Partial frame abandoned by timeout, then Space.
    push_exp(0, 1, 12); send_frame(8'h00, 1'b0, 5);
    repeat (50200) @(negedge clk);
    push_exp(1, 0, 16); send(8'h29);

    // Typematic repeats and an unmapped code.
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 0, 9); send(8'h42);
    end
    send(8'h0E);

    // Reset at the internal fall of a data bit mid-frame.
    push_exp(0, 0, 31);
    send_frame(8'h4B, 1'b0, 4);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    check("midframe_reset_key", int'(KEY_PRESSED), 31);
    check("midframe_reset_valid", int'(key_valid), 0);
    check("midframe_reset_err", int'(frame_err), 0);
    repeat (200) @(negedge clk);

    push_exp(1, 0, 11); send(8'h4B);
    push_exp(0, 0, 31); send(8'hF0); send(8'h4B);

    repeat (50) @(negedge clk);
    check("events_outstanding", exp_q.size(), 0);
    check("final_key", int'(KEY_PRESSED), 31);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
